// File: rtl/mem_arbiter_n.sv
// N-master to single-slave memory bus arbiter: round-robin or fixed-priority
// selection, with LOCK-held sequences that keep the bus on one master.
module mem_arbiter_n #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 16,
  parameter int FIXED_PRIORITY = 0,
  localparam int BSEL = DATA_WIDTH / 8,
  localparam int IDW  = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
  output logic [DATA_WIDTH-1:0]             m_data_in,
  input  logic [NUM_MASTERS-1:0]            m_access,
  output logic [NUM_MASTERS-1:0]            m_ack,
  input  logic [NUM_MASTERS-1:0]            m_wr_en,
  input  logic [NUM_MASTERS*BSEL-1:0]       m_bytesel,
  input  logic [NUM_MASTERS-1:0]            m_io,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_data_out,
  input  logic [DATA_WIDTH-1:0]             s_data_in,
  output logic                              s_access,
  input  logic                              s_ack,
  output logic                              s_wr_en,
  output logic [BSEL-1:0]                   s_bytesel,
  output logic                              s_io,
  output logic                              grant_valid,
  output logic [IDW-1:0]                    grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;

  state_t          state, state_next;
  logic [IDW-1:0]  grant_id_next;
  logic [IDW-1:0]  last_id, last_id_next;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];
  logic [BSEL-1:0]       bsel_arr  [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
    assign bsel_arr[i]  = m_bytesel[i*BSEL +: BSEL];
  end

  // Slave side is always a mux of the current owner; s_access gates validity.
  assign s_addr      = addr_arr[grant_id];
  assign s_data_out  = wdata_arr[grant_id];
  assign s_bytesel   = bsel_arr[grant_id];
  assign s_wr_en     = m_wr_en[grant_id];
  assign s_io        = m_io[grant_id];
  assign m_data_in   = s_data_in;
  assign grant_valid = (state != IDLE);

  logic cur_access, cur_lock, done;
  assign cur_access = m_access[grant_id];
  assign cur_lock   = m_lock[grant_id];
  assign done       = s_ack & cur_access;

  // low_id: lowest requester; high_id: lowest requester above last_id.
  logic [IDW-1:0] low_id, high_id, winner;
  logic           low_found, high_found;

  always_comb begin
    low_id     = '0;
    high_id    = '0;
    low_found  = 1'b0;
    high_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (m_access[i] && !low_found) begin
        low_found = 1'b1;
        low_id    = IDW'(i);
      end
      if (m_access[i] && !high_found && (IDW'(i) > last_id)) begin
        high_found = 1'b1;
        high_id    = IDW'(i);
      end
    end
  end

  assign winner = ((FIXED_PRIORITY != 0) || !high_found) ? low_id : high_id;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant_id <= '0;
      last_id  <= IDW'(NUM_MASTERS - 1);
    end else begin
      state    <= state_next;
      grant_id <= grant_id_next;
      last_id  <= last_id_next;
    end
  end

  always_comb begin
    state_next    = state;
    grant_id_next = grant_id;
    last_id_next  = last_id;
    s_access      = 1'b0;
    m_ack         = '0;
    case (state)
      IDLE: begin
        if (|m_access) begin
          grant_id_next = winner;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        s_access        = cur_access;
        m_ack[grant_id] = done;
        if (!cur_access) begin
          state_next = IDLE;
        end else if (s_ack) begin
          last_id_next = grant_id;
          state_next   = cur_lock ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        s_access        = cur_access;
        m_ack[grant_id] = done;
        if (done) begin
          last_id_next = grant_id;
          if (!cur_lock) state_next = IDLE;
        end else if (!cur_lock && !cur_access) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n: round-robin and fixed-priority instances
// share one stimulus stream and are checked against a rule-level model.
module tb_mem_arbiter_n;
  localparam int N  = 3;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int BS = DW / 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [N*AW-1:0]     m_addr;
  logic [N*DW-1:0]     m_data_out;
  logic [N-1:0]        m_access, m_wr_en, m_io, m_lock;
  logic [N*BS-1:0]     m_bytesel;
  logic [DW-1:0]       s_data_in;
  logic                s_ack;

  logic [1:0][DW-1:0]  o_mdin, o_sdout;
  logic [1:0][N-1:0]   o_mack;
  logic [1:0][AW-1:0]  o_saddr;
  logic [1:0][BS-1:0]  o_sbs;
  logic [1:0][IW-1:0]  o_gid;
  logic [1:0]          o_sacc, o_swr, o_sio, o_gv;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter_n #(
      .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(k)
    ) dut (
      .clk(clk), .reset(reset),
      .m_addr(m_addr), .m_data_out(m_data_out), .m_data_in(o_mdin[k]),
      .m_access(m_access), .m_ack(o_mack[k]), .m_wr_en(m_wr_en),
      .m_bytesel(m_bytesel), .m_io(m_io), .m_lock(m_lock),
      .s_addr(o_saddr[k]), .s_data_out(o_sdout[k]), .s_data_in(s_data_in),
      .s_access(o_sacc[k]), .s_ack(s_ack), .s_wr_en(o_swr[k]),
      .s_bytesel(o_sbs[k]), .s_io(o_sio[k]),
      .grant_valid(o_gv[k]), .grant_id(o_gid[k])
    );
  end

  // Stimulus variables, packed onto the DUT ports once per cycle.
  logic          rstn, sack;
  logic [DW-1:0] sdin;
  logic [N-1:0]  acc, wr, io, lk, pend, ack_pred;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdat [N];
  logic [BS-1:0] bsel [N];

  typedef struct packed {
    logic          sacc;
    logic [AW-1:0] saddr;
    logic [DW-1:0] sdout;
    logic          swr;
    logic [BS-1:0] sbs;
    logic          sio;
    logic [N-1:0]  mack;
    logic          gv;
    logic [IW-1:0] gid;
    logic [DW-1:0] mdin;
  } exp_t;

  // Model: owner = -1 when no master holds the bus.
  typedef struct {
    int owner;
    bit locked;
    int gid;
    int last;
  } mdl_t;

  mdl_t md [2];
  exp_t ex_rr[$], ex_fp[$];
  bit   mv = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]     = addr[i];
      m_data_out[i*DW +: DW] = wdat[i];
      m_bytesel[i*BS +: BS]  = bsel[i];
    end
    m_access  = acc;
    m_wr_en   = wr;
    m_io      = io;
    m_lock    = lk;
    reset     = rstn;
    s_ack     = sack;
    s_data_in = sdin;
  endtask

  function automatic exp_t predict(input int k);
    exp_t e;
    int   g;
    e      = '0;
    e.mdin = sdin;
    e.gid  = IW'(md[k].gid);
    e.gv   = (md[k].owner >= 0);
    if (md[k].owner >= 0) begin
      g         = md[k].owner;
      e.sacc    = acc[g];
      e.saddr   = addr[g];
      e.sdout   = wdat[g];
      e.swr     = wr[g];
      e.sbs     = bsel[g];
      e.sio     = io[g];
      e.mack[g] = sack & acc[g];
    end
    return e;
  endfunction

  function automatic int pick(input int k);
    int i;
    if (k == 1) begin
      for (int j = 0; j < N; j++) if (acc[j]) return j;
    end else begin
      for (int d = 1; d <= N; d++) begin
        i = (md[k].last + d) % N;
        if (acc[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic void advance(input int k);
    int g;
    bit done;
    if (!rstn) begin
      md[k] = '{-1, 1'b0, 0, N - 1};
      return;
    end
    if (md[k].owner < 0) begin
      if (acc != '0) begin
        g           = pick(k);
        md[k].owner = g;
        md[k].gid   = g;
      end
      return;
    end
    g    = md[k].owner;
    done = sack && acc[g];
    if (done) md[k].last = g;
    if (!md[k].locked) begin
      if (!acc[g]) md[k].owner = -1;
      else if (done) begin
        if (lk[g]) md[k].locked = 1'b1;
        else md[k].owner = -1;
      end
    end else if (done ? !lk[g] : (!lk[g] && !acc[g])) begin
      md[k].owner = -1;
    end
    if (md[k].owner < 0) md[k].locked = 1'b0;
  endfunction

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    apply();
    e        = predict(0);
    ack_pred = e.mack;
    if (mv) begin
      ex_rr.push_back(e);
      ex_fp.push_back(predict(1));
    end
    advance(0);
    advance(1);
    if (!rstn) mv = 1'b1;
  endtask

  task automatic compare(input int k, input exp_t e);
    string p;
    p = (k == 0) ? "rr" : "fp";
    chk({p, ".s_access"},    64'(o_sacc[k]), 64'(e.sacc));
    chk({p, ".m_ack"},       64'(o_mack[k]), 64'(e.mack));
    chk({p, ".grant_valid"}, 64'(o_gv[k]),   64'(e.gv));
    chk({p, ".grant_id"},    64'(o_gid[k]),  64'(e.gid));
    chk({p, ".m_data_in"},   64'(o_mdin[k]), 64'(e.mdin));
    if (e.sacc) begin
      chk({p, ".s_addr"},     64'(o_saddr[k]), 64'(e.saddr));
      chk({p, ".s_data_out"}, 64'(o_sdout[k]), 64'(e.sdout));
      chk({p, ".s_wr_en"},    64'(o_swr[k]),   64'(e.swr));
      chk({p, ".s_bytesel"},  64'(o_sbs[k]),   64'(e.sbs));
      chk({p, ".s_io"},       64'(o_sio[k]),   64'(e.sio));
    end
  endtask

  always @(negedge clk) begin
    if (ex_rr.size() > 0) compare(0, ex_rr.pop_front());
    if (ex_fp.size() > 0) compare(1, ex_fp.pop_front());
  end

  int   gr_rr[$], gr_fp[$];
  logic [1:0] prev_gv;
  int   rr_order [4] = '{0, 1, 2, 0};

  initial begin
    for (int k = 0; k < 2; k++) md[k] = '{-1, 1'b0, 0, N - 1};
    rstn = 1'b0; sack = 1'b0; sdin = '0;
    acc = '0; wr = '0; io = '0; lk = '0; pend = '0; ack_pred = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(i * 16'h111);
      wdat[i] = DW'(i * 16'h1010);
      bsel[i] = '1;
    end
    apply();

    // Reset state
    cycle();
    cycle();
    rstn = 1'b1;
    cycle();
    #2;
    chk("rst.grant_valid", 64'(o_gv[0]),   64'(0));
    chk("rst.grant_id",    64'(o_gid[0]),  64'(0));
    chk("rst.s_access",    64'(o_sacc[0]), 64'(0));
    chk("rst.m_ack",       64'(o_mack[0]), 64'(0));

    // Single master 1 write, slave acks at cycle 3
    acc = 3'b010; addr[1] = 19'h12345; wr[1] = 1'b1;
    cycle(); #2;
    chk("single.c0_s_access", 64'(o_sacc[0]), 64'(0));
    cycle(); #2;
    chk("single.c1_s_access", 64'(o_sacc[0]),  64'(1));
    chk("single.c1_s_addr",   64'(o_saddr[0]), 64'(19'h12345));
    chk("single.c1_grant_id", 64'(o_gid[0]),   64'(1));
    cycle();
    sack = 1'b1;
    cycle(); #2;
    chk("single.c3_m_ack",   64'(o_mack[0]), 64'(3'b010));
    chk("single.c3_s_wr_en", 64'(o_swr[0]),  64'(1));
    sack = 1'b0; acc = '0;
    cycle(); #2;
    chk("single.c4_grant_valid", 64'(o_gv[0]), 64'(0));

    // All three request continuously with immediate acks
    rstn = 1'b0; acc = 3'b111; sack = 1'b1; wr = '0;
    cycle();
    rstn = 1'b1;
    prev_gv = 2'b00;
    for (int c = 0; c < 8; c++) begin
      cycle(); #2;
      if (o_gv[0] && !prev_gv[0]) gr_rr.push_back(int'(o_gid[0]));
      if (o_gv[1] && !prev_gv[1]) gr_fp.push_back(int'(o_gid[1]));
      prev_gv = o_gv;
    end
    chk("rr.grant_count", 64'(gr_rr.size()), 64'(4));
    chk("fp.grant_count", 64'(gr_fp.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("rr.grant_order", 64'((i < gr_rr.size()) ? gr_rr[i] : -1), 64'(rr_order[i]));
      chk("fp.grant_order", 64'((i < gr_fp.size()) ? gr_fp[i] : -1), 64'(0));
    end

    // Master 0 holds lock across two accesses while master 1 waits
    rstn = 1'b0; acc = '0; sack = 1'b0;
    cycle();
    rstn = 1'b1; acc = 3'b011; lk = 3'b001;
    cycle();
    sack = 1'b1;
    cycle(); #2;
    chk("lock.first_ack", 64'(o_mack[0]), 64'(3'b001));
    sack = 1'b0;
    cycle(); #2;
    chk("lock.held_grant_id", 64'(o_gid[0]),  64'(0));
    chk("lock.held_s_access", 64'(o_sacc[0]), 64'(1));
    sack = 1'b1; lk = '0;
    cycle(); #2;
    chk("lock.second_ack", 64'(o_mack[0]), 64'(3'b001));
    chk("lock.second_gid", 64'(o_gid[0]),  64'(0));
    sack = 1'b0; acc = 3'b010;
    cycle(); #2;
    chk("lock.gap_grant_valid", 64'(o_gv[0]), 64'(0));
    cycle(); #2;
    chk("lock.m1_grant_id",    64'(o_gid[0]), 64'(1));
    chk("lock.m1_grant_valid", 64'(o_gv[0]),  64'(1));
    sack = 1'b1;
    cycle();
    sack = 1'b0; acc = '0;
    cycle();

    // Master 1 aborts before ack, then re-requests alone
    acc = 3'b010; wr[1] = 1'b1;
    cycle();
    cycle();
    acc = '0;
    cycle(); #2;
    chk("abort.m_ack",    64'(o_mack[0]), 64'(0));
    chk("abort.s_access", 64'(o_sacc[0]), 64'(0));
    acc = 3'b010;
    cycle();
    cycle(); #2;
    chk("abort.regrant_id", 64'(o_gid[0]), 64'(1));
    chk("abort.regrant_gv", 64'(o_gv[0]),  64'(1));

    // Reset pulse while busy, then simultaneous requests from 0 and 1
    rstn = 1'b0;
    cycle();
    rstn = 1'b1; acc = 3'b011; wr[0] = 1'b0;
    cycle(); #2;
    chk("midrst.s_access",    64'(o_sacc[0]), 64'(0));
    chk("midrst.grant_valid", 64'(o_gv[0]),   64'(0));
    sack = 1'b1; sdin = 16'hBEEF;
    cycle(); #2;
    chk("read.grant_id",  64'(o_gid[0]),  64'(0));
    chk("read.m_data_in", 64'(o_mdin[0]), 64'(16'hBEEF));
    chk("read.m_ack",     64'(o_mack[0]), 64'(3'b001));
    sack = 1'b0; acc = '0;
    cycle();

    // Randomized traffic with aborts, lock toggling and rare resets
    pend = '0; lk = '0;
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          addr[i] = AW'($urandom);
          wdat[i] = DW'($urandom);
          bsel[i] = BS'($urandom);
          wr[i]   = 1'($urandom);
          io[i]   = 1'($urandom);
        end else if (pend[i] && $urandom_range(0, 29) == 0) begin
          pend[i] = 1'b0;
        end
        if ($urandom_range(0, 5) == 0) lk[i] = ~lk[i];
      end
      acc  = pend;
      sack = 1'($urandom);
      sdin = DW'($urandom);
      rstn = ($urandom_range(0, 149) != 0);
      cycle();
      pend = pend & ~ack_pred;
    end

    rstn = 1'b1; acc = '0; sack = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
